// File: rtl/msgdma_st_pkg.sv
// Shared mSGDMA streaming constants, lane index type and parity helper.
// Used by the width downsizer and any future width upsizer.
package msgdma_st_pkg;

  localparam int MSGDMA_DATA_W = 256;
  localparam int MSGDMA_BEAT_W = 64;
  localparam int MSGDMA_RATIO  = MSGDMA_DATA_W / MSGDMA_BEAT_W;
  localparam int MSGDMA_LANE_W = $clog2(MSGDMA_RATIO);

  typedef logic [MSGDMA_LANE_W-1:0] lane_idx_t;

  // Even parity bit: set when the data has an odd number of ones.
  function automatic logic even_parity(
    input logic [MSGDMA_DATA_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/msgdma_lane_mux.sv
// RATIO:1 beat selector over a wide word, lane 0 in the low bits.
// Optional parity output under MSGDMA_DOWNSIZER_PARITY_EN.
module msgdma_lane_mux
  import msgdma_st_pkg::*;
#(
  parameter int IN_WIDTH  = MSGDMA_DATA_W,
  parameter int OUT_WIDTH = MSGDMA_BEAT_W,
  parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int LANE_W    = $clog2(RATIO)
) (
  input  logic [IN_WIDTH-1:0]  i_word,
  input  logic [LANE_W-1:0]    i_lane,
`ifdef MSGDMA_DOWNSIZER_PARITY_EN
  output logic                 o_parity,
`endif
  output logic [OUT_WIDTH-1:0] o_beat
);

  logic [OUT_WIDTH-1:0] w_beats [RATIO];

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    assign w_beats[g] = i_word[g*OUT_WIDTH +: OUT_WIDTH];
  end

  assign o_beat = w_beats[i_lane];

`ifdef MSGDMA_DOWNSIZER_PARITY_EN
  assign o_parity = even_parity(MSGDMA_DATA_W'(o_beat));
`endif

endmodule

// File: rtl/msgdma_st_width_downsizer.sv
// mSGDMA read-path downsizer: one IN_WIDTH word out as RATIO beats.
// Option: MSGDMA_DOWNSIZER_PARITY_EN adds the out_parity port.
module msgdma_st_width_downsizer
  import msgdma_st_pkg::*;
#(
  parameter int IN_WIDTH  = MSGDMA_DATA_W,
  parameter int OUT_WIDTH = MSGDMA_BEAT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
`ifdef MSGDMA_DOWNSIZER_PARITY_EN
  output logic                 out_parity,
`endif
  output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] out_lane,
  output logic                 out_last
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST = LANE_W'(RATIO - 1);

  logic [IN_WIDTH-1:0] r_hold;
  logic                r_hold_valid;
  logic [LANE_W-1:0]   r_lane;

  logic w_last;
  logic w_in_acc;
  logic w_out_acc;

  assign w_last    = r_hold_valid && (r_lane == LAST);
  assign in_ready  = !flush && (!r_hold_valid || (out_ready && w_last));
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = r_hold_valid && out_ready;

  assign out_valid = r_hold_valid;
  assign out_lane  = r_lane;
  assign out_last  = w_last;

  // Word capture; contents are meaningless while r_hold_valid is low.
  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_hold <= in_data;
    end
  end

  // Hold-valid flag and lane counter; flush wins over a load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_lane       <= '0;
    end else if (flush) begin
      r_hold_valid <= 1'b0;
      r_lane       <= '0;
    end else if (w_in_acc) begin
      r_hold_valid <= 1'b1;
      r_lane       <= '0;
    end else if (w_out_acc) begin
      if (r_lane == LAST) begin
        r_hold_valid <= 1'b0;
        r_lane       <= '0;
      end else begin
        r_lane <= r_lane + LANE_W'(1);
      end
    end
  end

`ifdef MSGDMA_DOWNSIZER_PARITY_EN
  logic w_parity;

  msgdma_lane_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO),
    .LANE_W    (LANE_W)
  ) u_mux (
    .i_word   (r_hold),
    .i_lane   (r_lane),
    .o_parity (w_parity),
    .o_beat   (out_data)
  );

  // Forced low while idle so the unreset hold cannot leak through.
  assign out_parity = r_hold_valid && w_parity;
`else
  msgdma_lane_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .RATIO     (RATIO),
    .LANE_W    (LANE_W)
  ) u_mux (
    .i_word (r_hold),
    .i_lane (r_lane),
    .o_beat (out_data)
  );
`endif

endmodule

// File: tb/tb_msgdma_st_width_downsizer.sv
// Directed bench for msgdma_st_width_downsizer (256 -> 4 x 64).
// Covers reset, lane order, back-to-back, stalls, flush, reset mid-word.
module tb_msgdma_st_width_downsizer;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [1:0]   out_lane;
  logic         out_last;
`ifdef MSGDMA_DOWNSIZER_PARITY_EN
  logic         out_parity;
`endif

  int n_pass;
  int n_total;

  msgdma_st_width_downsizer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MSGDMA_DOWNSIZER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [255:0] mkw(
    input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] b2, input logic [63:0] b3
  );
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [63:0] sbeat(input int w, input int k);
    return {16'hC0DE, 16'(w), 32'(k)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q[$];
  logic [15:0] lfsr;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic [1:0]  prev_lane;
  int          wn;
  bit          drained;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step(); step();
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_iready", 64'(in_ready), 64'd1);
    chk("rst_lane", 64'(out_lane), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    reset_n = 1'b1;
    step();

    // Basic lane order
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = mkw(64'h0, 64'h1, 64'h2, 64'h3);
    #1 chk("t1_accept", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_data", out_data, 64'(k));
      chk("t1_lane", 64'(out_lane), 64'(k));
      chk("t1_last", 64'(out_last), 64'(k == 3));
      chk("t1_iready", 64'(in_ready), 64'(k == 3));
      step();
    end
    chk("t1_idle", 64'(out_valid), 64'd0);

    // Back-to-back 8 words, no bubbles
    in_valid = 1'b1;
    in_data  = mkw(sbeat(100, 0), sbeat(100, 1),
                   sbeat(100, 2), sbeat(100, 3));
    step();
    for (int c = 0; c < 32; c++) begin
      int w;
      int k;
      w = c / 4;
      k = c % 4;
      if (k == 3) begin
        if (w < 7) begin
          in_data = mkw(sbeat(101 + w, 0), sbeat(101 + w, 1),
                        sbeat(101 + w, 2), sbeat(101 + w, 3));
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_data", out_data, sbeat(100 + w, k));
      chk("t2_iready", 64'(in_ready), 64'(k == 3));
      step();
    end
    chk("t2_idle", 64'(out_valid), 64'd0);

    // Random out_ready, scoreboard and stall stability
    lfsr       = 16'd23;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_lane  = '0;
    wn         = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid  = 1'b1;
      in_data   = mkw(sbeat(wn, 0), sbeat(wn, 1),
                      sbeat(wn, 2), sbeat(wn, 3));
      out_ready = lfsr[0];
      #1;
      if (prev_stall) begin
        chk("t3_stall_v", 64'(out_valid), 64'd1);
        chk("t3_stall_d", out_data, prev_data);
        chk("t3_stall_l", 64'(out_lane), 64'(prev_lane));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("t3_sb_empty", 64'd1, 64'd0);
        else chk("t3_sb", out_data, q.pop_front());
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < 4; k++) q.push_back(sbeat(wn, k));
        wn++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_lane  = out_lane;
      step();
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drained   = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      #1;
      if (!out_valid) drained = 1'b1;
      else begin
        if (q.size() == 0) chk("t3_dr_empty", 64'd1, 64'd0);
        else chk("t3_drain", out_data, q.pop_front());
        step();
      end
    end
    chk("t3_drained", 64'(drained), 64'd1);
    chk("t3_q_left", 64'(q.size()), 64'd0);
    chk("t3_words", 64'(wn > 10), 64'd1);

    // Flush on lane 1 of word A with word B offered
    step();
    in_valid = 1'b1;
    in_data  = mkw(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    step();
    in_valid = 1'b0;
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mkw(64'hB0, 64'hB1, 64'hB2, 64'hB3);
    #1;
    chk("t4_lane1", 64'(out_lane), 64'd1);
    chk("t4_data1", out_data, 64'hA1);
    chk("t4_iready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("t4_ovalid", 64'(out_valid), 64'd0);
    chk("t4_iready2", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("t4_bvalid", 64'(out_valid), 64'd1);
    chk("t4_blane", 64'(out_lane), 64'd0);
    chk("t4_bdata", out_data, 64'hB0);

    // Reset asserted on lane 2
    step(); step();
    chk("t5_lane2", 64'(out_lane), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("t5_async", 64'(out_valid), 64'd0);
    #1 reset_n = 1'b1;
    #1;
    chk("t5_iready", 64'(in_ready), 64'd1);
    chk("t5_lane", 64'(out_lane), 64'd0);

`ifdef MSGDMA_DOWNSIZER_PARITY_EN
    step();
    chk("t6_par_idle", 64'(out_parity), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = mkw(64'h1, 64'h3, 64'h7, 64'h0);
    step();
    in_valid = 1'b0;
    chk("t6_par_1", 64'(out_parity), 64'd1);
    step();
    chk("t6_par_3", 64'(out_parity), 64'd0);
    step();
    chk("t6_par_7", 64'(out_parity), 64'd1);
    step();
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/msgdma_st_width_downsizer.md
# msgdma_st_width_downsizer

Streaming width downsizer on the mSGDMA read-data path. It sits directly downstream of the 256-bit timing-adapter FIFO and consumes one 256-bit word per valid/ready handshake. It emits that word as four 64-bit beats, lowest lane first, onto a valid/ready sink. Both sides use ready-latency-0 semantics, and the block sustains one output beat per clock.

## Interface
- IN_WIDTH, 256, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output beat width.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH = 4, beats per input word.
- LANE_W (localparam), $clog2(RATIO) = 2, lane index width.
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of the held word and lane state.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  IN_WIDTH  upstream word.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  OUT_WIDTH  current beat.
- out_lane  out  LANE_W  lane index of the current beat (0..RATIO-1).
- out_last  out  1  high on the final lane (RATIO-1) of a word.
- out_parity  out  1  even parity of out_data; present only with MSGDMA_DOWNSIZER_PARITY_EN.

## Operation
- State: holding register hold[IN_WIDTH-1:0], flag hold_valid, lane counter lane[LANE_W-1:0].
- out_valid = hold_valid.
- out_data = hold[lane*OUT_WIDTH +: OUT_WIDTH].
- out_lane = lane.
- out_last = hold_valid && lane == RATIO-1.
- Output beat accepted (out_valid && out_ready) with lane < RATIO-1: lane increments.
- Output beat accepted with lane == RATIO-1: lane wraps to 0 and hold_valid clears, unless a new word is accepted in the same cycle.
- in_ready = !flush && (!hold_valid || (out_ready && out_last)).
- Input accepted (in_valid && in_ready): hold <= in_data, hold_valid <= 1, lane <= 0.
- Simultaneous last-beat accept and input accept: the new word loads and hold_valid stays 1. There is no bubble, giving 4 beats per 4 cycles sustained.
- flush: hold_valid <= 0 and lane <= 0. The hold contents are don't-care. flush overrides an input accept in the same cycle (in_ready is low).
- A partially emitted word is discarded by flush. There is no other way to abort a word.
- The hold register is not reset; only hold_valid and lane are reset.

## Timing
- Reset values: out_valid 0, in_ready 1, out_lane 0, out_last 0, out_parity 0. out_data is don't-care while out_valid is 0.
- Latency: a word accepted at edge N presents lane 0 from edge N onward, so first beat valid the cycle after the input handshake.
- Combinational path out_ready -> in_ready exists (one AND level). There is no path from in_data to out_data.
- out_data, out_valid and out_lane hold stable while out_valid && !out_ready.
- Reset asserted mid-word: the word is lost and out_valid drops asynchronously.

## Configuration
- MSGDMA_DOWNSIZER_PARITY_EN defined: the out_parity port exists and equals ^out_data, combinational from hold and lane. It carries the same timing as out_data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package msgdma_st_pkg holds:
  - the MSGDMA_DATA_W = 256 and MSGDMA_BEAT_W = 64 constants,
  - the lane index typedef,
  - the parity helper function used by this block and any future upsizer.
- One sub-module is natural: msgdma_lane_mux (parameterised RATIO:1 beat selector plus optional parity), reused by the upsizer.

## Test plan
- After reset, in_data = 0x0003_..._0002_..._0001_..._0000 (lane k = 64'hk), out_ready = 1 -> out_data 0, 1, 2, 3 on four consecutive cycles. out_last is high only on lane 3. in_ready is low for lanes 0-2.
- Back-to-back words with in_valid and out_ready held at 1 for 8 words -> 32 beats in 32 cycles. There are no out_valid gaps, and in_ready pulses on each lane-3 cycle.
- out_ready toggling with seed 23 for 200 cycles -> the beat sequence matches the scoreboard in order, and beats hold stable across stall cycles.
- flush asserted while on lane 1 of word A with in_valid = 1 (word B) -> in_ready = 0 that cycle. The next cycle out_valid = 0, then word B is accepted and emits from lane 0.
- reset_n pulled low mid-word on lane 2 -> out_valid drops immediately. After release, in_ready = 1 and out_lane = 0.
- With MSGDMA_DOWNSIZER_PARITY_EN, beat 64'h1 -> out_parity 1, and beat 64'h3 -> out_parity 0.
